// File: rtl/if_fetch_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_fetch_ctrl_pkg : fetch FSM state and redirect-source encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Numeric order doubles as priority: a larger code is more urgent.
  typedef enum logic [1:0] {
    RDR_NONE = 2'd0,
    RDR_BR   = 2'd1,
    RDR_EXC  = 2'd2,
    RDR_DBG  = 2'd3
  } rdr_src_t;

  function automatic logic rdr_is_trap(input rdr_src_t src);
    return (src == RDR_EXC) || (src == RDR_DBG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_ctrl_redirect_latch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// redirect_latch : single-entry pending redirect with debug > exception > branch
// Rev 1.0
// ----------------------------------------------------------------------------
module redirect_latch
  import if_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_br_req,
  input  logic [31:0] i_br_pc,
  input  logic        i_exc_req,
  input  logic [31:0] i_exc_pc,
  input  logic        i_dbg_req,
  input  logic [31:0] i_dbg_pc,
  input  logic        i_clear,
  output logic [1:0]  o_src,
  output logic [31:0] o_tgt
);

  rdr_src_t    r_src;
  logic [31:0] r_tgt;
  rdr_src_t    w_in_src;
  logic [31:0] w_in_tgt;
  rdr_src_t    w_src;
  logic [31:0] w_tgt;

  always_comb begin
    w_in_src = RDR_NONE;
    w_in_tgt = 32'd0;
    if (i_dbg_req) begin
      w_in_src = RDR_DBG;
      w_in_tgt = i_dbg_pc;
    end else if (i_exc_req) begin
      w_in_src = RDR_EXC;
      w_in_tgt = i_exc_pc;
    end else if (i_br_req) begin
      w_in_src = RDR_BR;
      w_in_tgt = i_br_pc;
    end

    // Equal priority replaces, so the newest target of a given kind wins.
    w_src = r_src;
    w_tgt = r_tgt;
    if ((w_in_src != RDR_NONE) && (w_in_src >= r_src)) begin
      w_src = w_in_src;
      w_tgt = w_in_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_src <= RDR_NONE;
      r_tgt <= 32'd0;
    end else begin
      r_src <= w_src;
      r_tgt <= w_tgt;
    end
  end

  assign o_src = w_src;
  assign o_tgt = w_tgt;

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_fetch_ctrl : instruction fetch sequencing, decode hand-off and PC redirect
// Rev 1.0
// ----------------------------------------------------------------------------
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc_cur,
  input  logic        i_stall,
  input  logic        i_br_req,
  input  logic [31:0] i_br_pc,
  input  logic        i_exc_req,
  input  logic [31:0] i_exc_pc,
  input  logic        i_dbg_req,
  input  logic [31:0] i_dbg_pc,
  output logic        o_ibus_req,
  output logic [31:0] o_ibus_addr,
  input  logic        i_ibus_ack,
  input  logic [31:0] i_ibus_rdata,
  output logic        o_pc_enable,
  output logic        o_is_branch,
  output logic        o_is_exception,
  output logic        o_is_debug,
  output logic [31:0] o_branch_address,
  output logic [31:0] o_exception_new_pc,
  output logic [31:0] o_debug_new_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_hold_inst;
  logic [31:0]  r_hold_pc;
  logic         w_capture;
  logic         w_clear;
  logic         w_pc_en;
  logic [1:0]   w_src_bits;
  rdr_src_t     w_src;
  logic [31:0]  w_tgt;

  redirect_latch u_redirect_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_br_req  (i_br_req),
    .i_br_pc   (i_br_pc),
    .i_exc_req (i_exc_req),
    .i_exc_pc  (i_exc_pc),
    .i_dbg_req (i_dbg_req),
    .i_dbg_pc  (i_dbg_pc),
    .i_clear   (w_clear),
    .o_src     (w_src_bits),
    .o_tgt     (w_tgt)
  );

  assign w_src = rdr_src_t'(w_src_bits);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_inst <= 32'd0;
      r_hold_pc   <= 32'd0;
    end else if (w_capture) begin
      r_hold_inst <= i_ibus_rdata;
      r_hold_pc   <= i_pc_cur;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_capture          = 1'b0;
    w_clear            = 1'b0;
    w_pc_en            = 1'b0;
    o_ibus_req         = 1'b0;
    o_ibus_addr        = 32'd0;
    o_inst_valid       = 1'b0;
    o_inst             = 32'd0;
    o_inst_pc          = 32'd0;
    o_pc_enable        = 1'b0;
    o_is_branch        = 1'b0;
    o_is_exception     = 1'b0;
    o_is_debug         = 1'b0;
    o_branch_address   = 32'd0;
    o_exception_new_pc = 32'd0;
    o_debug_new_pc     = 32'd0;

    // Everything stays quiet while reset is asserted, even mid-fetch.
    if (rst_n) begin
      case (r_state)
        S_BOOT: begin
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          o_ibus_req  = 1'b1;
          o_ibus_addr = i_pc_cur;
          if (i_ibus_ack) begin
            if (rdr_is_trap(w_src)) begin
              w_pc_en = 1'b1;
              w_clear = 1'b1;
            end else if (!i_stall) begin
              o_inst_valid = 1'b1;
              o_inst       = i_ibus_rdata;
              o_inst_pc    = i_pc_cur;
              w_pc_en      = 1'b1;
              w_clear      = 1'b1;
            end else begin
              // A pending branch rides along into HOLD for the delay slot.
              w_capture   = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (rdr_is_trap(w_src)) begin
            w_pc_en     = 1'b1;
            w_clear     = 1'b1;
            w_state_nxt = S_WAIT;
          end else if (!i_stall) begin
            o_inst_valid = 1'b1;
            o_inst       = r_hold_inst;
            o_inst_pc    = r_hold_pc;
            w_pc_en      = 1'b1;
            w_clear      = 1'b1;
            w_state_nxt  = S_WAIT;
          end
        end
        default: begin
          w_state_nxt = S_BOOT;
        end
      endcase

      o_pc_enable        = w_pc_en;
      o_is_branch        = w_pc_en && (w_src == RDR_BR);
      o_is_exception     = w_pc_en && (w_src == RDR_EXC);
      o_is_debug         = w_pc_en && (w_src == RDR_DBG);
      o_branch_address   = (w_src == RDR_BR)  ? w_tgt : 32'd0;
      o_exception_new_pc = (w_src == RDR_EXC) ? w_tgt : 32'd0;
      o_debug_new_pc     = (w_src == RDR_DBG) ? w_tgt : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl : directed scenarios plus randomized traffic vs. a reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  localparam logic [31:0] BOOT_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_pc_cur;
  logic        i_stall;
  logic        i_br_req, i_exc_req, i_dbg_req;
  logic [31:0] i_br_pc, i_exc_pc, i_dbg_pc;
  logic        o_ibus_req;
  logic [31:0] o_ibus_addr;
  logic        i_ibus_ack;
  logic [31:0] i_ibus_rdata;
  logic        o_pc_enable, o_is_branch, o_is_exception, o_is_debug;
  logic [31:0] o_branch_address, o_exception_new_pc, o_debug_new_pc;
  logic        o_inst_valid;
  logic [31:0] o_inst, o_inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_pc_cur           (i_pc_cur),
    .i_stall            (i_stall),
    .i_br_req           (i_br_req),
    .i_br_pc            (i_br_pc),
    .i_exc_req          (i_exc_req),
    .i_exc_pc           (i_exc_pc),
    .i_dbg_req          (i_dbg_req),
    .i_dbg_pc           (i_dbg_pc),
    .o_ibus_req         (o_ibus_req),
    .o_ibus_addr        (o_ibus_addr),
    .i_ibus_ack         (i_ibus_ack),
    .i_ibus_rdata       (i_ibus_rdata),
    .o_pc_enable        (o_pc_enable),
    .o_is_branch        (o_is_branch),
    .o_is_exception     (o_is_exception),
    .o_is_debug         (o_is_debug),
    .o_branch_address   (o_branch_address),
    .o_exception_new_pc (o_exception_new_pc),
    .o_debug_new_pc     (o_debug_new_pc),
    .o_inst_valid       (o_inst_valid),
    .o_inst             (o_inst),
    .o_inst_pc          (o_inst_pc)
  );

  // Reference model: phase 0=boot 1=fetching 2=holding; src is redirect urgency 0..3.
  int          m_phase = 0, m_src = 0;
  logic [31:0] m_tgt = 0, m_hw = 0, m_hpc = 0, m_pc = BOOT_PC;
  int          n_phase, n_src;
  logic [31:0] n_tgt, n_hw, n_hpc;
  logic        e_req, e_pce, e_br, e_ex, e_dbg, e_iv;
  logic [31:0] e_addr, e_bta, e_eta, e_dta, e_inst, e_ipc;

  // Snapshots of the DUT taken at the sample point of the latest cycle.
  logic        s_req, s_pce, s_br, s_ex, s_dbg, s_iv;
  logic [31:0] s_addr, s_bta, s_eta, s_dta, s_inst, s_ipc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int          in_src, ms;
    logic [31:0] in_tgt, mt;
    in_src = 0;
    in_tgt = 32'd0;
    if (i_dbg_req)      begin in_src = 3; in_tgt = i_dbg_pc; end
    else if (i_exc_req) begin in_src = 2; in_tgt = i_exc_pc; end
    else if (i_br_req)  begin in_src = 1; in_tgt = i_br_pc;  end
    ms = m_src;
    mt = m_tgt;
    if (in_src != 0 && in_src >= m_src) begin ms = in_src; mt = in_tgt; end

    {e_req, e_pce, e_br, e_ex, e_dbg, e_iv} = '0;
    {e_addr, e_bta, e_eta, e_dta, e_inst, e_ipc} = '0;
    n_phase = m_phase; n_src = ms; n_tgt = mt; n_hw = m_hw; n_hpc = m_hpc;

    if (!rst_n) begin
      n_phase = 0;
      n_src   = 0;
      n_tgt   = 32'd0;
    end else begin
      e_bta = (ms == 1) ? mt : 32'd0;
      e_eta = (ms == 2) ? mt : 32'd0;
      e_dta = (ms == 3) ? mt : 32'd0;
      if (m_phase == 0) begin
        n_phase = 1;
      end else if (m_phase == 1) begin
        e_req  = 1'b1;
        e_addr = i_pc_cur;
        if (i_ibus_ack) begin
          if (ms >= 2) begin
            e_pce = 1'b1; n_src = 0;
          end else if (!i_stall) begin
            e_iv = 1'b1; e_inst = i_ibus_rdata; e_ipc = i_pc_cur;
            e_pce = 1'b1; n_src = 0;
          end else begin
            n_phase = 2; n_hw = i_ibus_rdata; n_hpc = i_pc_cur;
          end
        end
      end else begin
        if (ms >= 2) begin
          e_pce = 1'b1; n_src = 0; n_phase = 1;
        end else if (!i_stall) begin
          e_iv = 1'b1; e_inst = m_hw; e_ipc = m_hpc;
          e_pce = 1'b1; n_src = 0; n_phase = 1;
        end
      end
      e_br  = e_pce && (ms == 1);
      e_ex  = e_pce && (ms == 2);
      e_dbg = e_pce && (ms == 3);
    end
  endtask

  task automatic tick();
    #2;
    model_eval();
    s_req = o_ibus_req;  s_addr = o_ibus_addr; s_pce = o_pc_enable;
    s_br  = o_is_branch; s_ex   = o_is_exception; s_dbg = o_is_debug;
    s_bta = o_branch_address; s_eta = o_exception_new_pc; s_dta = o_debug_new_pc;
    s_iv  = o_inst_valid; s_inst = o_inst; s_ipc = o_inst_pc;
    chk("ibus_req", s_req, e_req);
    chk("ibus_addr", s_addr, e_addr);
    chk("pc_enable", s_pce, e_pce);
    chk("is_branch", s_br, e_br);
    chk("is_exception", s_ex, e_ex);
    chk("is_debug", s_dbg, e_dbg);
    chk("branch_address", s_bta, e_bta);
    chk("exception_new_pc", s_eta, e_eta);
    chk("debug_new_pc", s_dta, e_dta);
    chk("inst_valid", s_iv, e_iv);
    chk("inst", s_inst, e_inst);
    chk("inst_pc", s_ipc, e_ipc);
    @(posedge clk);
    #1;
    // PC register the DUT steers: redirect target, else sequential.
    if (!rst_n)      m_pc = BOOT_PC;
    else if (e_pce)  m_pc = e_br ? e_bta : e_ex ? e_eta : e_dbg ? e_dta : m_pc + 32'd4;
    m_phase = n_phase; m_src = n_src; m_tgt = n_tgt; m_hw = n_hw; m_hpc = n_hpc;
    i_pc_cur = m_pc;
    @(negedge clk);
  endtask

  task automatic cyc(input logic st, input logic ack, input logic [31:0] rd,
                     input logic br, input logic ex, input logic db);
    i_stall = st; i_ibus_ack = ack; i_ibus_rdata = rd;
    i_br_req = br; i_exc_req = ex; i_dbg_req = db;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 32'd0, 0, 0, 0);
    cyc(0, 0, 32'd0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  int nvalid;

  initial begin
    rst_n = 1'b0; i_pc_cur = BOOT_PC; i_stall = 0; i_ibus_ack = 0; i_ibus_rdata = 0;
    i_br_req = 0; i_exc_req = 0; i_dbg_req = 0;
    i_br_pc = 0; i_exc_pc = 0; i_dbg_pc = 0;
    @(negedge clk);

    // Boot, then first fetch completes on the second WAIT cycle.
    do_reset();
    cyc(0, 0, 32'd0, 0, 0, 0);
    chk("boot_req", s_req, 1'b0);
    chk("boot_pce", s_pce, 1'b0);
    cyc(0, 0, 32'd0, 0, 0, 0);
    chk("wait1_addr", s_addr, BOOT_PC);
    cyc(0, 1, 32'h2408_0001, 0, 0, 0);
    chk("first_iv", s_iv, 1'b1);
    chk("first_inst_pc", s_ipc, BOOT_PC);
    chk("first_inst", s_inst, 32'h2408_0001);
    chk("first_pce", s_pce, 1'b1);

    // Stalled ack, held for three cycles, delivered exactly once.
    nvalid = 0;
    cyc(1, 1, 32'h8c09_0000, 0, 0, 0); nvalid += int'(s_iv);
    cyc(1, 0, 32'd0, 0, 0, 0);         nvalid += int'(s_iv);
    cyc(1, 0, 32'd0, 0, 0, 0);         nvalid += int'(s_iv);
    cyc(0, 0, 32'd0, 0, 0, 0);         nvalid += int'(s_iv);
    chk("hold_release_inst", s_inst, 32'h8c09_0000);
    chk("hold_release_pc", s_ipc, 32'hbfc0_0004);
    cyc(0, 0, 32'd0, 0, 0, 0);         nvalid += int'(s_iv);
    chk("hold_single_delivery", nvalid, 1);
    chk("hold_next_addr", s_addr, 32'hbfc0_0008);

    // Branch posted during fetch of 0xbfc00008; word goes out as delay slot.
    i_br_pc = 32'hbfc0_0100;
    cyc(0, 0, 32'd0, 1, 0, 0);
    cyc(0, 1, 32'h27bd_fff8, 0, 0, 0);
    chk("br_slot_iv", s_iv, 1'b1);
    chk("br_slot_pc", s_ipc, 32'hbfc0_0008);
    chk("br_is_branch", s_br, 1'b1);
    chk("br_target", s_bta, 32'hbfc0_0100);
    cyc(0, 0, 32'd0, 0, 0, 0);
    chk("br_next_addr", s_addr, 32'hbfc0_0100);

    // Exception hits a stalled HOLD and drops the held word.
    cyc(1, 1, 32'h8fbf_0010, 0, 0, 0);
    cyc(1, 0, 32'd0, 0, 0, 0);
    i_exc_pc = 32'hbfc0_0380;
    cyc(1, 0, 32'd0, 0, 1, 0);
    chk("exc_iv", s_iv, 1'b0);
    chk("exc_pce", s_pce, 1'b1);
    chk("exc_flag", s_ex, 1'b1);
    cyc(1, 0, 32'd0, 0, 0, 0);
    chk("exc_next_addr", s_addr, 32'hbfc0_0380);

    // Branch, then debug, then exception on the ack: debug alone wins.
    i_br_pc = 32'hbfc0_0400; i_dbg_pc = 32'hff20_0200;
    cyc(0, 0, 32'd0, 1, 0, 0);
    cyc(0, 0, 32'd0, 0, 0, 1);
    cyc(0, 1, 32'h1234_5678, 0, 1, 0);
    chk("dbg_flag", s_dbg, 1'b1);
    chk("dbg_no_exc", s_ex, 1'b0);
    chk("dbg_no_br", s_br, 1'b0);
    chk("dbg_iv", s_iv, 1'b0);
    chk("dbg_target", s_dta, 32'hff20_0200);

    // Reset lands on an ack cycle; an ack in BOOT is ignored.
    cyc(0, 0, 32'd0, 0, 0, 0);
    rst_n = 1'b0;
    cyc(0, 1, 32'hdead_beef, 0, 0, 0);
    chk("rst_iv", s_iv, 1'b0);
    chk("rst_req", s_req, 1'b0);
    chk("rst_pce", s_pce, 1'b0);
    rst_n = 1'b1;
    cyc(0, 1, 32'hcafe_f00d, 0, 0, 0);
    chk("boot_ack_iv", s_iv, 1'b0);
    chk("boot_ack_req", s_req, 1'b0);
    cyc(0, 0, 32'd0, 0, 0, 0);
    chk("reboot_addr", s_addr, BOOT_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      i_br_pc  = $urandom() & 32'hffff_fffc;
      i_exc_pc = $urandom() & 32'hffff_fffc;
      i_dbg_pc = $urandom() & 32'hffff_fffc;
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4), $urandom(),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
